// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: captures an ROWS x COLS matrix and a COLS vector, accumulates one
// column per cycle across all rows in parallel, then registers the result vector and its total.
module matvec_engine #(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   parameter  int DW   = 8,
   localparam int ACCW = 2*DW + $clog2(COLS),
   localparam int SUMW = ACCW + $clog2(ROWS)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_signed_mode,
   input  logic [ROWS*COLS*DW-1:0]   i_a_data,
   input  logic [COLS*DW-1:0]        i_b_data,
   output logic [ROWS*ACCW-1:0]      o_c_data,
   output logic [SUMW-1:0]           o_sum,
   output logic                      o_busy,
   output logic                      o_done
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [CW-1:0]             r_col;
   logic [ROWS*COLS*DW-1:0]   r_a;
   logic [COLS*DW-1:0]        r_b;
   logic                      r_signed;
   logic [ROWS*ACCW-1:0]      w_accFlat;
   logic [DW-1:0]             w_bElem;
   logic [SUMW-1:0]           w_total;
   logic                      w_capture;
   logic                      w_macEn;
   logic                      w_sumEn;
   logic                      w_lastCol;

   // Widening helpers: sign-extend when the captured mode is signed, zero-extend otherwise.
   function automatic logic [2*DW-1:0] extProd(input logic [DW-1:0] v, input logic s);
      logic signed [DW-1:0] vs;
      vs = v;
      return s ? (2*DW)'(vs) : (2*DW)'(v);
   endfunction

   function automatic logic [ACCW-1:0] extAcc(input logic [2*DW-1:0] v, input logic s);
      logic signed [2*DW-1:0] vs;
      vs = v;
      return s ? ACCW'(vs) : ACCW'(v);
   endfunction

   function automatic logic [SUMW-1:0] extSum(input logic [ACCW-1:0] v, input logic s);
      logic signed [ACCW-1:0] vs;
      vs = v;
      return s ? SUMW'(vs) : SUMW'(v);
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_col   <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture)
            r_col <= '0;
         else if (w_macEn)
            r_col <= r_col + CW'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_MAC;
         S_MAC:   if (w_lastCol) w_next = S_SUM;
         S_SUM:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_capture = (r_state == S_IDLE) && i_start;
      w_macEn   = (r_state == S_MAC);
      w_sumEn   = (r_state == S_SUM);
      w_lastCol = (r_col == CW'(COLS - 1));
      o_busy    = (r_state == S_MAC) || (r_state == S_SUM);
      o_done    = (r_state == S_DONE);
   end

   // Operands are only needed while busy, so they are captured without reset.
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         r_a      <= i_a_data;
         r_b      <= i_b_data;
         r_signed <= i_signed_mode;
      end
   end

   assign w_bElem = r_b[int'(r_col)*DW +: DW];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DW-1:0]   w_aElem;
      logic [2*DW-1:0] w_prod;
      logic [ACCW-1:0] r_acc;

      assign w_aElem = r_a[(r*COLS + int'(r_col))*DW +: DW];
      assign w_prod  = extProd(w_aElem, r_signed) * extProd(w_bElem, r_signed);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            r_acc <= '0;
         else if (w_capture)
            r_acc <= '0;
         else if (w_macEn)
            r_acc <= r_acc + extAcc(w_prod, r_signed);
      end

      assign w_accFlat[r*ACCW +: ACCW] = r_acc;
   end

   always_comb begin
      w_total = '0;
      for (int r = 0; r < ROWS; r++)
         w_total = w_total + extSum(w_accFlat[r*ACCW +: ACCW], r_signed);
   end

   // Results update only on the SUM edge and otherwise hold for the host.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_c_data <= '0;
         o_sum    <= '0;
      end else if (w_sumEn) begin
         o_c_data <= w_accFlat;
         o_sum    <= w_total;
      end
   end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed self-checking bench for matvec_engine: default-sized instance plus a 4x16x4 instance.
module tb_matvec_engine;

   localparam int ROWS = 8, COLS = 8, DW = 8, ACCW = 19, SUMW = 22;
   localparam int R2 = 4, C2 = 16, D2 = 4, ACCW2 = 12, SUMW2 = 14;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start, signedMode;
   logic [ROWS*COLS*DW-1:0]  aData;
   logic [COLS*DW-1:0]       bData;
   logic [ROWS*ACCW-1:0]     cData;
   logic [SUMW-1:0]          sum;
   logic                     busy, done;

   logic                     start2;
   logic [R2*C2*D2-1:0]      aData2;
   logic [C2*D2-1:0]         bData2;
   logic [R2*ACCW2-1:0]      cData2;
   logic [SUMW2-1:0]         sum2;
   logic                     busy2, done2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   matvec_engine dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed_mode(signedMode),
      .i_a_data(aData), .i_b_data(bData), .o_c_data(cData), .o_sum(sum),
      .o_busy(busy), .o_done(done)
   );

   matvec_engine #(.ROWS(R2), .COLS(C2), .DW(D2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_signed_mode(1'b0),
      .i_a_data(aData2), .i_b_data(bData2), .o_c_data(cData2), .o_sum(sum2),
      .o_busy(busy2), .o_done(done2)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkRows(input string tag, input logic [ACCW-1:0] val);
      for (int r = 0; r < ROWS; r++)
         checkOutput($sformatf("%s c[%0d]", tag, r), 64'(cData[r*ACCW +: ACCW]), 64'(val));
   endtask

   task automatic setRamp();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            aData[(r*COLS+c)*DW +: DW] = 8'(16*r + c + 1);
      for (int c = 0; c < COLS; c++)
         bData[c*DW +: DW] = 8'(129 + c);
   endtask

   task automatic setUniform(input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < ROWS*COLS; i++)
         aData[i*DW +: DW] = av;
      for (int c = 0; c < COLS; c++)
         bData[c*DW +: DW] = bv;
   endtask

   // Pulses start, checks busy/done across edges 1..9 and returns just after edge 9.
   task automatic applyStimulus(input string tag, input logic sm, input logic flipMode);
      @(negedge clk);
      signedMode = sm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (flipMode) signedMode = ~sm;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s busy e%0d", tag, k), 64'(busy), 64'd1);
         checkOutput($sformatf("%s done e%0d", tag, k), 64'(done), 64'd0);
      end
      @(negedge clk);
      checkOutput($sformatf("%s done e9", tag), 64'(done), 64'd1);
      checkOutput($sformatf("%s busy e9", tag), 64'(busy), 64'd0);
   endtask

   task automatic finishOp(input string tag);
      @(negedge clk);
      checkOutput($sformatf("%s done e10", tag), 64'(done), 64'd0);
   endtask

   task automatic checkRampResult(input string tag);
      for (int r = 0; r < ROWS; r++)
         checkOutput($sformatf("%s c[%0d]", tag, r), 64'(cData[r*ACCW +: ACCW]), 64'(4812 + 16960*r));
      checkOutput({tag, " sum"}, 64'(sum), 64'h07D560);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      signedMode = 1'b0;
      aData = '0;
      bData = '0;
      aData2 = '0;
      bData2 = '0;

      #1;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset c_data", 64'(|cData), 64'd0);
      checkOutput("reset sum", 64'(sum), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      setRamp();
      applyStimulus("ramp", 1'b0, 1'b0);
      checkRampResult("ramp");
      finishOp("ramp");
      checkOutput("ramp hold c0", 64'(cData[0 +: ACCW]), 64'h012CC);
      checkOutput("ramp hold c7", 64'(cData[7*ACCW +: ACCW]), 64'h1E28C);

      setUniform(8'hFF, 8'h7F);
      applyStimulus("signed", 1'b1, 1'b1);
      checkRows("signed", 19'h7FC08);
      checkOutput("signed sum", 64'(sum), 64'h3FE040);
      finishOp("signed");

      applyStimulus("unsigned7F", 1'b0, 1'b0);
      checkRows("unsigned7F", 19'h3F408);
      checkOutput("unsigned7F sum", 64'(sum), 64'h1FA040);
      finishOp("unsigned7F");

      setUniform(8'hFF, 8'hFF);
      applyStimulus("maxval", 1'b0, 1'b0);
      checkRows("maxval", 19'h7F008);
      checkOutput("maxval sum", 64'(sum), 64'h3F8040);
      finishOp("maxval");

      // Start held high for edges 0..19: ops accepted at edges 0 and 11 only.
      setRamp();
      signedMode = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k <= 23; k++) begin
         @(negedge clk);
         if (k == 2) setUniform(8'hFF, 8'h00);
         if (k == 2) for (int c = 0; c < COLS; c++) bData[c*DW +: DW] = 8'(129 + c);
         if (k == 19) start = 1'b0;
         if (k >= 1)
            checkOutput($sformatf("held done e%0d", k), 64'(done), 64'((k == 9) || (k == 20)));
         if (k == 9) checkRampResult("held op1");
         if (k == 20) begin
            checkRows("held op2", 19'h41FDC);
            checkOutput("held op2 sum", 64'(sum), 64'h20FEE0);
         end
      end

      // Reset asserted between edges 3 and 4 of an operation.
      setRamp();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst busy", 64'(busy), 64'd0);
      checkOutput("midrst done", 64'(done), 64'd0);
      checkOutput("midrst c_data", 64'(|cData), 64'd0);
      checkOutput("midrst sum", 64'(sum), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst nodone %0d", k), 64'(done), 64'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput($sformatf("postrst nodone %0d", k), 64'(done), 64'd0);
      end
      applyStimulus("postrst", 1'b0, 1'b0);
      checkRampResult("postrst");
      finishOp("postrst");

      // Small instance: 16 columns, 4-bit operands.
      aData2 = '1;
      bData2 = '1;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         checkOutput($sformatf("small done e%0d", k), 64'(done2), 64'(k == 17));
      end
      checkOutput("small busy e17", 64'(busy2), 64'd0);
      for (int r = 0; r < R2; r++)
         checkOutput($sformatf("small c[%0d]", r), 64'(cData2[r*ACCW2 +: ACCW2]), 64'h0E10);
      checkOutput("small sum", 64'(sum2), 64'h3840);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
